// File: rtl/mem_writer_pkg.sv
// Shared constants for the CPU write-side sequencer: widths, stack page,
// request mode codes and FSM state encodings.
package mem_writer_pkg;

  localparam int          MW_REG_WIDTH  = 8;
  localparam int          MW_ADDR_WIDTH = 16;
  localparam logic [15:0] MW_STACK_BASE = 16'h0100;

  localparam logic [1:0] WR_MODE_STORE = 2'd0;
  localparam logic [1:0] WR_MODE_RMW   = 2'd1;
  localparam logic [1:0] WR_MODE_PUSH1 = 2'd2;
  localparam logic [1:0] WR_MODE_PUSH3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_STORE  = 3'd1,
    ST_RMW_DUMMY = 3'd2,
    ST_RMW_FINAL = 3'd3,
    ST_PUSH_HI   = 3'd4,
    ST_PUSH_LO   = 3'd5,
    ST_PUSH_P    = 3'd6
  } wr_state_e;

endpackage

// File: rtl/mem_writer.sv
// CPU bus write sequencer: plain store, RMW double write, 1-byte push and
// 3-byte interrupt push, with stack-pointer update on pushes.
//
// state        | meaning
// ST_IDLE      | waiting for start, outputs hold last bus values
// ST_WR_STORE  | single store write cycle (done)
// ST_RMW_DUMMY | RMW first write of the original operand
// ST_RMW_FINAL | RMW second write of the result (done)
// ST_PUSH_HI   | interrupt push of PC high byte at SP
// ST_PUSH_LO   | interrupt push of PC low byte at SP-1
// ST_PUSH_P    | final push byte: PUSH1 data at SP or status at SP-2 (done, sp_we)
module mem_writer
  import mem_writer_pkg::*;
#(
  parameter int                     REG_WIDTH  = MW_REG_WIDTH,
  parameter int                     ADDR_WIDTH = MW_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  STACK_BASE = ADDR_WIDTH'(MW_STACK_BASE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  data_in,
  input  logic [REG_WIDTH-1:0]  old_data,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0]  status,
  input  logic [REG_WIDTH-1:0]  sp_in,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_data,
  output logic                  mem_we,
  output logic [REG_WIDTH-1:0]  sp_out,
  output logic                  sp_we
);

  wr_state_e             state;
  logic [REG_WIDTH-1:0]  data_q;
  logic [REG_WIDTH-1:0]  pc_lo_q;
  logic [REG_WIDTH-1:0]  status_q;
  logic [REG_WIDTH-1:0]  sp_q;

  // Stack writes never leave the stack page: SP wraps modulo 2^REG_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [REG_WIDTH-1:0] s);
    return STACK_BASE | ADDR_WIDTH'(s);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_we   <= 1'b0;
      sp_we    <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      sp_out   <= '0;
      data_q   <= '0;
      pc_lo_q  <= '0;
      status_q <= '0;
      sp_q     <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      sp_we  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            mem_we   <= 1'b1;
            data_q   <= data_in;
            pc_lo_q  <= pc[REG_WIDTH-1:0];
            status_q <= status;
            sp_q     <= sp_in;
            case (mode)
              WR_MODE_STORE: begin
                state    <= ST_WR_STORE;
                mem_addr <= addr_in;
                mem_data <= data_in;
                done     <= 1'b1;
              end
              WR_MODE_RMW: begin
                state    <= ST_RMW_DUMMY;
                mem_addr <= addr_in;
                mem_data <= old_data;
              end
              WR_MODE_PUSH1: begin
                state    <= ST_PUSH_P;
                mem_addr <= stack_addr(sp_in);
                mem_data <= data_in;
                done     <= 1'b1;
                sp_we    <= 1'b1;
                sp_out   <= sp_in - REG_WIDTH'(1);
              end
              WR_MODE_PUSH3: begin
                state    <= ST_PUSH_HI;
                mem_addr <= stack_addr(sp_in);
                mem_data <= pc[2*REG_WIDTH-1:REG_WIDTH];
              end
            endcase
          end
        end
        // mem_addr already holds the effective address from the dummy write
        ST_RMW_DUMMY: begin
          state    <= ST_RMW_FINAL;
          mem_data <= data_q;
          mem_we   <= 1'b1;
          done     <= 1'b1;
        end
        ST_PUSH_HI: begin
          state    <= ST_PUSH_LO;
          mem_addr <= stack_addr(sp_q - REG_WIDTH'(1));
          mem_data <= pc_lo_q;
          mem_we   <= 1'b1;
        end
        ST_PUSH_LO: begin
          state    <= ST_PUSH_P;
          mem_addr <= stack_addr(sp_q - REG_WIDTH'(2));
          mem_data <= status_q;
          mem_we   <= 1'b1;
          done     <= 1'b1;
          sp_we    <= 1'b1;
          sp_out   <= sp_q - REG_WIDTH'(3);
        end
        ST_WR_STORE, ST_RMW_FINAL, ST_PUSH_P: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: expected bus writes are queued when a
// request is driven and compared by a negedge monitor as they appear.
module tb_mem_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] addr_in = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  old_data = '0;
  logic [15:0] pc = '0;
  logic [7:0]  status = '0;
  logic [7:0]  sp_in = '0;
  logic        busy, done, mem_we, sp_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, sp_out;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        done;
    logic        sp_we;
    logic [7:0]  sp_out;
  } wr_t;

  wr_t sb[$];

  mem_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .addr_in(addr_in), .data_in(data_in), .old_data(old_data), .pc(pc),
    .status(status), .sp_in(sp_in), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .sp_out(sp_out), .sp_we(sp_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(logic [15:0] a, logic [7:0] d, logic dn, logic sw, logic [7:0] so);
    wr_t e;
    e.addr = a; e.data = d; e.done = dn; e.sp_we = sw; e.sp_out = so;
    return e;
  endfunction

  // Reference model of the write sequence for one request.
  task automatic expect_writes(input logic [1:0] m, input logic [15:0] a, input logic [7:0] d,
                               input logic [7:0] od, input logic [15:0] p, input logic [7:0] st,
                               input logic [7:0] s);
    logic [7:0] s1, s2, s3;
    s1 = s - 8'd1; s2 = s - 8'd2; s3 = s - 8'd3;
    case (m)
      2'd0: sb.push_back(mk(a, d, 1'b1, 1'b0, 8'h00));
      2'd1: begin
        sb.push_back(mk(a, od, 1'b0, 1'b0, 8'h00));
        sb.push_back(mk(a, d, 1'b1, 1'b0, 8'h00));
      end
      2'd2: sb.push_back(mk({8'h01, s}, d, 1'b1, 1'b1, s1));
      default: begin
        sb.push_back(mk({8'h01, s}, p[15:8], 1'b0, 1'b0, 8'h00));
        sb.push_back(mk({8'h01, s1}, p[7:0], 1'b0, 1'b0, 8'h00));
        sb.push_back(mk({8'h01, s2}, st, 1'b1, 1'b1, s3));
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        chk("busy_on_write", {31'd0, busy}, 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_write", {16'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
          chk("mem_data", {24'd0, mem_data}, {24'd0, e.data});
          chk("done", {31'd0, done}, {31'd0, e.done});
          chk("sp_we", {31'd0, sp_we}, {31'd0, e.sp_we});
          if (e.sp_we) chk("sp_out", {24'd0, sp_out}, {24'd0, e.sp_out});
        end
      end else begin
        chk("done_without_we", {31'd0, done}, 32'd0);
        chk("sp_we_without_we", {31'd0, sp_we}, 32'd0);
      end
    end
  end

  // Drive a request; returns #1 after the accept edge with start still per hold.
  task automatic req(input logic [1:0] m, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] od, input logic [15:0] p, input logic [7:0] st,
                     input logic [7:0] s, input bit hold);
    mode = m; addr_in = a; data_in = d; old_data = od; pc = p; status = st; sp_in = s;
    start = 1'b1;
    expect_writes(m, a, d, od, p, st, s);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("first_write_immediate", {31'd0, mem_we}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, exp_cycles);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sp_we", {31'd0, sp_we}, 32'd0);
    chk("rst_addr_data_sp", {mem_addr, mem_data, sp_out}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    req(2'd0, 16'h0234, 8'hA5, 8'h00, 16'h0000, 8'h00, 8'hFD, 1'b0);
    wait_idle("lat_store", 1);
    chk("store_hold_addr", {16'd0, mem_addr}, 32'h0234);

    req(2'd0, 16'h1234, 8'h3C, 8'h00, 16'h0000, 8'h00, 8'hFD, 1'b0);
    wait_idle("lat_store_b2b", 1);

    req(2'd1, 16'h0010, 8'h80, 8'h40, 16'h0000, 8'h00, 8'hFD, 1'b0);
    wait_idle("lat_rmw", 2);

    req(2'd2, 16'h0000, 8'h77, 8'h00, 16'h0000, 8'h00, 8'h00, 1'b0);
    wait_idle("lat_push1", 1);

    req(2'd3, 16'h0000, 8'h00, 8'h00, 16'hC123, 8'h34, 8'hFD, 1'b0);
    wait_idle("lat_push3", 3);

    req(2'd3, 16'h0000, 8'h00, 8'h00, 16'hBEEF, 8'h21, 8'h01, 1'b0);
    wait_idle("lat_push3_wrap", 3);

    // start held through PUSH3 while inputs switch to a STORE request
    req(2'd3, 16'h0000, 8'h00, 8'h00, 16'h8001, 8'h5B, 8'h80, 1'b1);
    mode = 2'd0; addr_in = 16'h0300; data_in = 8'h5A; pc = 16'h0000; status = 8'hFF; sp_in = 8'h10;
    expect_writes(2'd0, 16'h0300, 8'h5A, 8'h00, 16'h0000, 8'h00, 8'h10);
    wait_idle("lat_push3_held", 3);
    chk("idle_gap_no_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_start_accept", {31'd0, mem_we}, 32'd1);
    wait_idle("lat_store_after_held", 1);

    // reset during PUSH_LO after its write has been observed
    req(2'd3, 16'h0000, 8'h00, 8'h00, 16'hA55A, 8'h99, 8'h40, 1'b0);
    @(posedge clk);
    #7 reset_n = 1'b0;
    #1;
    chk("async_mem_we", {31'd0, mem_we}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_sp_we", {31'd0, sp_we}, 32'd0);
    chk("aborted_writes_left", sb.size(), 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    chk("post_rst_addr_sp", {mem_addr, sp_out}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_no_we", {31'd0, mem_we}, 32'd0);

    req(2'd0, 16'h0456, 8'hC3, 8'h00, 16'h0000, 8'h00, 8'h00, 1'b0);
    wait_idle("lat_store_after_rst", 1);

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
